ebr_ram_burst_reader: RTL and testbench

Read-side initiator for ebr_ram. It accepts a burst command (base address and length) and issues sequential read addresses on the RAM address handshake. It collects the returned words and streams them downstream with a last marker. Credit-based flow control guarantees that every issued read has buffer space, so RAM data is never dropped.

---
 rtl/ebr_ram_pkg.sv | 19 +
 rtl/ebr_rd_fifo.sv | 71 +++++++
 rtl/ebr_ram_burst_reader.sv | 155 +++++++++++++++
 tb/tb_ebr_ram_burst_reader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebr_ram_pkg.sv
// Shared width helpers and FSM state type for the ebr_ram burst reader.
package ebr_ram_pkg;

  function automatic int ebr_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a length of exactly DEPTH is representable.
  function automatic int ebr_len_w(input int depth);
    return ebr_addr_w(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ebr_rd_fifo.sv
// Return-data buffer for the burst reader: small synchronous FIFO whose head
// word is driven straight from storage flops, with occupancy count and flags.
module ebr_rd_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_wr_en,
  input  logic [WIDTH-1:0]             i_wr_data,
  input  logic                         i_rd_en,
  output logic [WIDTH-1:0]             o_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]  o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_fire;
  logic             rd_fire;

  assign o_full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign o_empty   = (count_q == '0);
  assign o_count   = count_q;
  assign wr_fire   = i_wr_en && !o_full;
  assign rd_fire   = i_rd_en && !o_empty;
  // Gate the head word so the stream data reads as zero whenever nothing is held.
  assign o_rd_data = o_empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_fire && !rd_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_fire && !wr_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

endmodule

// File: rtl/ebr_ram_burst_reader.sv
// Burst read initiator for ebr_ram: issues sequential read addresses under a
// credit limit and streams the returned words out with a last marker.
module ebr_ram_burst_reader
  import ebr_ram_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic [ebr_addr_w(DEPTH)-1:0] i_cmd_addr,
  input  logic [ebr_len_w(DEPTH)-1:0]  i_cmd_len,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  output logic [ebr_addr_w(DEPTH)-1:0] o_ram_addr,
  output logic                         o_ram_addr_valid,
  input  logic                         i_ram_addr_ready,
  input  logic [WIDTH-1:0]             i_ram_data,
  input  logic                         i_ram_valid,
  output logic                         o_ram_ready,
  output logic [WIDTH-1:0]             o_out_data,
  output logic                         o_out_last,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int ADDR_W = ebr_addr_w(DEPTH);
  localparam int LEN_W  = ebr_len_w(DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  rd_state_e         state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  beats_left_q, beats_left_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic              zero_done_q, zero_done_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  credits;
  logic              fifo_full, fifo_empty;
  logic [WIDTH-1:0]  fifo_data;
  logic              addr_hs, beat_ok, pop;

  assign addr_hs = o_ram_addr_valid && i_ram_addr_ready;
  // A beat with nothing outstanding is a protocol error and is not buffered.
  assign beat_ok = i_ram_valid && o_ram_ready && (outstanding_q != '0);
  assign pop     = o_out_valid && i_out_ready;
  assign credits = CNT_W'(FIFO_DEPTH) - outstanding_q - fifo_count;

  // run_q stays low from reset until the first edge so every output reads 0.
  assign o_ram_ready = run_q && !fifo_full;
  assign o_out_valid = !fifo_empty;
  assign o_out_data  = fifo_data;
  assign o_out_last  = o_out_valid && (beats_left_q == LEN_W'(1));
  assign o_ram_addr  = addr_q;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = zero_done_q || ((state_q == DRAIN) && pop && o_out_last);

  ebr_rd_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_wr_en   (beat_ok),
    .i_wr_data (i_ram_data),
    .i_rd_en   (i_out_ready),
    .o_rd_data (fifo_data),
    .o_count   (fifo_count),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    remaining_d      = remaining_q;
    beats_left_d     = beats_left_q;
    zero_done_d      = 1'b0;
    o_cmd_ready      = 1'b0;
    o_ram_addr_valid = 1'b0;

    case (state_q)
      IDLE: begin
        o_cmd_ready = run_q;
        if (i_cmd_valid && run_q) begin
          addr_d       = i_cmd_addr;
          remaining_d  = i_cmd_len;
          beats_left_d = i_cmd_len;
          if (i_cmd_len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        o_ram_addr_valid = (credits != '0);
        if (addr_hs) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && o_out_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop && (state_q != IDLE)) begin
      beats_left_d = beats_left_q - LEN_W'(1);
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (addr_hs && !beat_ok) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (beat_ok && !addr_hs) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      run_q         <= 1'b0;
      addr_q        <= '0;
      remaining_q   <= '0;
      beats_left_q  <= '0;
      outstanding_q <= '0;
      zero_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= 1'b1;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      beats_left_q  <= beats_left_d;
      outstanding_q <= outstanding_d;
      zero_done_q   <= zero_done_d;
    end
  end

  a_no_stray_beat: assert property (@(posedge i_clock) disable iff (!i_reset_n)
    !(i_ram_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_ebr_ram_burst_reader.sv
// Randomised scoreboard bench for ebr_ram_burst_reader with a behavioural RAM.
module tb_ebr_ram_burst_reader;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 1024;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = 10;
  localparam int LW         = 11;
  localparam int RAM_LAT    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] i_cmd_addr;
  logic [LW-1:0] i_cmd_len;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [AW-1:0] o_ram_addr;
  logic          o_ram_addr_valid;
  logic          i_ram_addr_ready;
  logic [7:0]    i_ram_data;
  logic          i_ram_valid;
  logic          o_ram_ready;
  logic [7:0]    o_out_data;
  logic          o_out_last;
  logic          o_out_valid;
  logic          i_out_ready;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  ebr_ram_burst_reader #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_cmd_addr       (i_cmd_addr),
    .i_cmd_len        (i_cmd_len),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .o_ram_addr       (o_ram_addr),
    .o_ram_addr_valid (o_ram_addr_valid),
    .i_ram_addr_ready (i_ram_addr_ready),
    .i_ram_data       (i_ram_data),
    .i_ram_valid      (i_ram_valid),
    .o_ram_ready      (o_ram_ready),
    .o_out_data       (o_out_data),
    .o_out_last       (o_out_last),
    .o_out_valid      (o_out_valid),
    .i_out_ready      (i_out_ready),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } rd_t;

  logic [7:0]    mem [DEPTH];
  beat_t         exp_q[$];
  logic [AW-1:0] addr_exp_q[$];
  rd_t           ram_q[$];

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int out_mode   = 0;
  int issued     = 0;
  int pops       = 0;
  bit zero_done_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic flag(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Behavioural RAM: accepts addresses, returns mem[addr] RAM_LAT cycles later,
  // holding each word until the DUT takes it.
  initial begin : ram_model
    bit  beat_fire;
    rd_t r;
    beat_fire        = 1'b0;
    i_ram_valid      = 1'b0;
    i_ram_data       = '0;
    i_ram_addr_ready = 1'b0;
    i_out_ready      = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ram_q.delete();
        beat_fire   = 1'b0;
        i_ram_valid = 1'b0;
        i_ram_data  = '0;
        continue;
      end
      if (beat_fire) void'(ram_q.pop_front());
      beat_fire = 1'b0;
      if (ram_q.size() > 0 && ram_q[0].due <= cyc) begin
        i_ram_valid = 1'b1;
        i_ram_data  = ram_q[0].data;
      end else begin
        i_ram_valid = 1'b0;
        i_ram_data  = '0;
      end
      case (out_mode)
        0:       i_out_ready = 1'b1;
        1:       i_out_ready = (cyc % 4 == 0);
        default: i_out_ready = 1'($urandom_range(0, 1));
      endcase
      i_ram_addr_ready = (out_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (!rst_n) continue;
      if (o_ram_addr_valid && i_ram_addr_ready) begin
        if (addr_exp_q.size() == 0)
          flag("ram_addr_unexpected", $sformatf("issue of 0x%0h with no burst address expected", o_ram_addr));
        else
          check("ram_addr", 32'(o_ram_addr), 32'(addr_exp_q.pop_front()));
        r.data = mem[o_ram_addr];
        r.due  = cyc + RAM_LAT;
        ram_q.push_back(r);
        issued++;
        check("inflight_le_depth", 32'(issued - pops <= FIFO_DEPTH), 32'(1));
      end
      if (i_ram_valid) begin
        check("ram_ready_on_beat", 32'(o_ram_ready), 32'(1));
        if (o_ram_ready) beat_fire = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each stream transfer and checks o_done.
  initial begin : monitor
    beat_t b;
    bit    exp_done;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) continue;
      exp_done = zero_done_pending;
      zero_done_pending = 1'b0;
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          flag("out_unexpected", $sformatf("word 0x%0h with nothing expected", o_out_data));
        end else begin
          b = exp_q.pop_front();
          check("out_data", 32'(o_out_data), 32'(b.data));
          check("out_last", 32'(o_out_last), 32'(b.last));
          if (b.last) exp_done = 1'b1;
        end
        pops++;
      end
      check("done", 32'(o_done), 32'(exp_done));
    end
  end

  task automatic send_cmd(input int a, input int len);
    int waited;
    int idx;
    beat_t b;
    waited = 0;
    @(negedge clk);
    while (!o_cmd_ready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (!o_cmd_ready) begin
      flag("cmd_ready_timeout", "o_cmd_ready never rose, required 1");
      return;
    end
    for (int k = 0; k < len; k++) begin
      idx    = (a + k) % DEPTH;
      b.data = mem[idx];
      b.last = (k == len - 1);
      exp_q.push_back(b);
      addr_exp_q.push_back(AW'(idx));
    end
    i_cmd_addr  = AW'(a);
    i_cmd_len   = LW'(len);
    i_cmd_valid = 1'b1;
    @(posedge clk);
    if (len == 0) zero_done_pending = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || addr_exp_q.size() != 0 || o_busy) && n < 20000) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 20000) begin
      flag({tag, "_timeout"}, $sformatf("%0d words still pending, required 0", exp_q.size()));
      exp_q.delete();
      addr_exp_q.delete();
    end
    @(negedge clk);
    #3;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({o_cmd_ready, o_ram_addr, o_ram_addr_valid, o_ram_ready, o_out_data,
                o_out_last, o_out_valid, o_busy, o_done});
  endfunction

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int p0;
    int n;
    rst_n       = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_len   = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);

    #1;
    check("reset_outputs", all_outputs(), 32'(0));
    repeat (3) @(negedge clk);
    #4 rst_n = 1'b1;
    @(negedge clk);
    #3;
    check("cmd_ready_after_reset", 32'(o_cmd_ready), 32'(1));

    repeat (1000) begin
      @(negedge clk);
      #3;
      check("idle_quiet", 32'({o_ram_addr_valid, o_out_valid, o_done, o_cmd_ready}), 32'h1);
    end

    out_mode = 0;
    send_cmd(10, 5);
    wait_idle("basic");
    send_cmd(1022, 4);
    wait_idle("wrap");

    out_mode = 1;
    send_cmd(100, 16);
    wait_idle("backpressure");
    out_mode = 0;

    send_cmd(5, 0);
    #3;
    check("len0_busy", 32'(o_busy), 32'(0));
    @(negedge clk);
    #3;
    check("len0_busy_next", 32'(o_busy), 32'(0));
    check("len0_done_single", 32'(o_done), 32'(0));

    // Commands presented while busy must be ignored.
    send_cmd(300, 12);
    @(negedge clk);
    i_cmd_addr  = AW'(7);
    i_cmd_len   = LW'(3);
    i_cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    i_cmd_valid = 1'b0;
    wait_idle("busy_ignore");

    // Reset in the middle of an 8-word burst.
    p0 = pops;
    send_cmd(200, 8);
    n = 0;
    while (pops - p0 < 3 && n < 1000) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("mid_reset_progress", 32'(pops - p0 >= 3), 32'(1));
    rst_n = 1'b0;
    #1;
    check("reset_outputs_mid", all_outputs(), 32'(0));
    exp_q.delete();
    addr_exp_q.delete();
    issued = 0;
    pops   = 0;
    zero_done_pending = 1'b0;
    repeat (2) @(negedge clk);
    #4 rst_n = 1'b1;
    @(negedge clk);
    #3;
    check("cmd_ready_after_mid_reset", 32'(o_cmd_ready), 32'(1));
    check("no_stale_valid", 32'(o_out_valid), 32'(0));
    send_cmd(0, 2);
    wait_idle("post_reset");

    send_cmd(517, DEPTH);
    wait_idle("full_depth");

    out_mode = 2;
    repeat (20) begin
      send_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)));
      wait_idle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
